// File: rtl/memory_dumper_pkg.sv
// Shared sizes, trit encoding and dumper state encoding for the memory dumper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package memory_dumper_pkg;

  localparam int WORD_SIZE     = 9;
  localparam int MEM_ADDR_SIZE = 9;

  // Balanced-ternary trit encoding; 2'b11 is not a legal trit.
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  typedef enum logic [2:0] {
    DUMP_IDLE   = 3'd0,
    DUMP_READ   = 3'd1,
    DUMP_WAIT   = 3'd2,
    DUMP_HOLD   = 3'd3,
    DUMP_FINISH = 3'd4
  } dump_state_t;

endpackage

// File: rtl/memory_dumper_ternary_incrementer.sv
// Combinational balanced-ternary +1 over NUM_TRITS trits, trit 0 in bits [1:0].
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module ternary_incrementer #(
  parameter int NUM_TRITS = 9
) (
  input  logic [2*NUM_TRITS-1:0] in_value,
  output logic [2*NUM_TRITS-1:0] out_value,
  output logic                   carry_out
);
  import memory_dumper_pkg::*;

  // Ripple a +1 from the least significant trit; POS rolls to NEG and carries.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    out_value = in_value;
    for (int i = 0; i < NUM_TRITS; i++) begin
      if (carry) begin
        unique case (in_value[2*i +: 2])
          TRIT_NEG: begin
            out_value[2*i +: 2] = TRIT_ZERO;
            carry               = 1'b0;
          end
          TRIT_ZERO: begin
            out_value[2*i +: 2] = TRIT_POS;
            carry               = 1'b0;
          end
          TRIT_POS: begin
            out_value[2*i +: 2] = TRIT_NEG;
            carry               = 1'b1;
          end
          default: begin
            // Illegal trit: leave it alone and stop propagating.
            carry = 1'b0;
          end
        endcase
      end
    end
    carry_out = carry;
  end

endmodule

// File: rtl/memory_dumper.sv
// Reads an inclusive ternary address range from RAM and streams each word out.
// Latency: first out_valid 3 cycles after start_dump; at best 1 word per 3 cycles.
// Backpressure: holds out_* stable while out_ready is low; no RAM reads while held.
module memory_dumper #(
  parameter int WORD_SIZE     = memory_dumper_pkg::WORD_SIZE,
  parameter int MEM_ADDR_SIZE = memory_dumper_pkg::MEM_ADDR_SIZE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_dump,
  input  logic [2*MEM_ADDR_SIZE-1:0] start_addr,
  input  logic [2*MEM_ADDR_SIZE-1:0] end_addr,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                       mem_read,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WORD_SIZE-1:0]     out_data,
  output logic [2*MEM_ADDR_SIZE-1:0] out_addr,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);
  import memory_dumper_pkg::*;

  localparam int AW = 2*MEM_ADDR_SIZE;
  localparam int DW = 2*WORD_SIZE;

  dump_state_t   state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] end_addr_q, end_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [AW-1:0] next_addr;
  logic          inc_carry_unused;

  ternary_incrementer #(
    .NUM_TRITS (MEM_ADDR_SIZE)
  ) u_addr_inc (
    .in_value  (cur_addr_q),
    .out_value (next_addr),
    .carry_out (inc_carry_unused)
  );

  // State and datapath registers; reset aborts any dump in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DUMP_IDLE;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_addr_q  <= end_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state and datapath updates: latch range, capture word, step address.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      DUMP_IDLE: begin
        if (start_dump) begin
          cur_addr_d = start_addr;
          end_addr_d = end_addr;
          state_d    = DUMP_READ;
        end
      end
      DUMP_READ: begin
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        // RAM data is valid now, one cycle after the read strobe.
        out_data_d  = mem_read_data;
        out_addr_d  = cur_addr_q;
        out_valid_d = 1'b1;
        out_last_d  = (cur_addr_q == end_addr_q);
        state_d     = DUMP_HOLD;
      end
      DUMP_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = DUMP_FINISH;
          end else begin
            cur_addr_d = next_addr;
            state_d    = DUMP_READ;
          end
        end
      end
      DUMP_FINISH: begin
        state_d = DUMP_IDLE;
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  // Outputs: strobes decoded from state, stream fields straight from registers.
  always_comb begin
    mem_addr  = cur_addr_q;
    mem_read  = (state_q == DUMP_READ);
    busy      = (state_q != DUMP_IDLE);
    done      = (state_q == DUMP_FINISH);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_addr  = out_addr_q;
    out_last  = out_last_q;
  end

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper with a one-cycle-latency RAM model.
// Latency: checks 3-cycle start-to-valid and done timing.
// Backpressure: exercises out_ready low while a word is held.
module tb_memory_dumper;

  logic        clock;
  logic        reset;
  logic        start_dump;
  logic [17:0] start_addr;
  logic [17:0] end_addr;
  logic [17:0] mem_addr;
  logic        mem_read;
  logic [17:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [17:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] got_addr[$];
  logic [17:0] got_data[$];
  logic        got_last[$];
  int          n_reads;
  bit          got_done;

  memory_dumper dut (
    .clock         (clock),
    .reset         (reset),
    .start_dump    (start_dump),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_read_data (mem_read_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM contents: each address holds its own pattern, some with 2'b11 trits.
  function automatic logic [17:0] ram_word(input logic [17:0] a);
    return a ^ 18'h3C3C3;
  endfunction

  always @(posedge clock) begin
    if (mem_read) mem_read_data <= ram_word(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a dump with out_ready high and collect words until done (bounded).
  task automatic run_dump(input logic [17:0] s, input logic [17:0] e, input int inject_at);
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    n_reads  = 0;
    got_done = 1'b0;
    start_addr = s;
    end_addr   = e;
    start_dump = 1'b1;
    out_ready  = 1'b1;
    tick();
    start_dump = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (mem_read) n_reads++;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (done) got_done = 1'b1;
      if (c == inject_at) begin
        start_dump = 1'b1;
        start_addr = 18'h00006;
        end_addr   = 18'h00006;
      end else begin
        start_dump = 1'b0;
      end
      if (!got_done) tick();
    end
    start_dump = 1'b0;
    check("dump_done_seen", got_done, 1);
  endtask

  task automatic check_words(input string tag, input logic [17:0] exp_a[$]);
    check({tag, "_count"}, got_addr.size(), exp_a.size());
    check({tag, "_reads"}, n_reads, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], exp_a[i]);
      check({tag, "_data"}, got_data[i], ram_word(exp_a[i]));
      check({tag, "_last"}, got_last[i], (i == exp_a.size() - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [17:0] exp_q[$];
    logic [17:0] held_a;
    logic [17:0] held_d;
    bit          seen;

    reset      = 1'b1;
    start_dump = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    check("rst_mem_read", mem_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
    reset = 1'b0;
    tick();

    // Single word at address 1, cycle-exact timing.
    start_addr = 18'h00001;
    end_addr   = 18'h00001;
    start_dump = 1'b1;
    out_ready  = 1'b1;
    tick();
    start_dump = 1'b0;
    check("single_c1_busy", busy, 1);
    check("single_c1_read", mem_read, 1);
    check("single_c1_maddr", mem_addr, 18'h00001);
    tick();
    check("single_c2_read", mem_read, 0);
    check("single_c2_valid", out_valid, 0);
    tick();
    check("single_c3_valid", out_valid, 1);
    check("single_c3_addr", out_addr, 18'h00001);
    check("single_c3_data", out_data, 18'h3C3C2);
    check("single_c3_last", out_last, 1);
    check("single_c3_done", done, 0);
    tick();
    check("single_c4_done", done, 1);
    check("single_c4_valid", out_valid, 0);
    tick();
    check("single_c5_done", done, 0);
    check("single_c5_busy", busy, 0);

    // Range -1 .. 2 through the ternary incrementer.
    run_dump(18'h00002, 18'h00006, -1);
    exp_q = '{18'h00002, 18'h00000, 18'h00001, 18'h00006};
    check_words("range", exp_q);
    tick();
    check("range_idle", busy, 0);

    // Wrap from all-POS to all-NEG.
    run_dump(18'h15555, 18'h2AAAA, -1);
    exp_q = '{18'h15555, 18'h2AAAA};
    check_words("wrap", exp_q);
    tick();

    // New start request mid-dump must not disturb the running range.
    run_dump(18'h00000, 18'h00001, 2);
    exp_q = '{18'h00000, 18'h00001};
    check_words("busy_start", exp_q);
    tick();
    check("busy_start_idle", busy, 0);

    // Backpressure: hold the first word of range -1 .. 0 for 5 cycles.
    out_ready  = 1'b0;
    start_addr = 18'h00002;
    end_addr   = 18'h00000;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("bp_first_valid", seen, 1);
    held_a = out_addr;
    held_d = out_data;
    check("bp_held_addr", held_a, 18'h00002);
    check("bp_held_data", held_d, ram_word(18'h00002));
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid_stable", out_valid, 1);
      check("bp_addr_stable", out_addr, 18'h00002);
      check("bp_data_stable", out_data, ram_word(18'h00002));
      check("bp_no_read", mem_read, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_after_hs_valid", out_valid, 0);
    check("bp_after_hs_read", mem_read, 1);
    check("bp_after_hs_maddr", mem_addr, 18'h00000);
    tick();
    tick();
    check("bp_second_valid", out_valid, 1);
    check("bp_second_addr", out_addr, 18'h00000);
    check("bp_second_data", out_data, ram_word(18'h00000));
    check("bp_second_last", out_last, 1);
    tick();
    check("bp_done", done, 1);
    tick();

    // Reset while a word is held.
    out_ready  = 1'b0;
    start_addr = 18'h00000;
    end_addr   = 18'h00006;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("rmid_reached_hold", seen, 1);
    reset = 1'b1;
    #1;
    check("rmid_valid", out_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_read", mem_read, 0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    reset = 1'b0;
    tick();
    if (done) seen = 1'b1;
    check("rmid_no_done", seen, 0);
    run_dump(18'h00001, 18'h00001, -1);
    exp_q = '{18'h00001};
    check_words("after_reset", exp_q);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
